// File: rtl/fetch_unit_if.sv
// Purpose: groups the fetch stage's memory and decode-side signals into one bundle.
// Latency: none, this is a plain signal bundle with no logic.
// Backpressure: imem_gnt stalls requests; inst_ready stalls the decode hand-off.
// Port summary:
//   imem_req/imem_addr    fetch -> memory read request and address
//   imem_gnt              memory -> fetch request accepted
//   imem_rvalid/rdata     memory -> fetch read response
//   inst_valid/inst       fetch -> decode fetched instruction
//   inst_ready            decode -> fetch instruction consumed
//   pc_next/pc_current    PC loop between fetch and the PC-select logic
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic        inst_ready;
  logic [31:0] pc_next;
  logic [31:0] pc_current;

  // master: the fetch unit itself
  modport master (
    output imem_req, imem_addr, inst_valid, inst, pc_current,
    input  imem_gnt, imem_rvalid, imem_rdata, inst_ready, pc_next
  );

  // slave: instruction memory plus decode/PC-select side
  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, pc_current,
    output imem_gnt, imem_rvalid, imem_rdata, inst_ready, pc_next
  );
endinterface

// File: rtl/fetch_unit.sv
// Purpose: instruction fetch stage; owns the PC and issues one imem read per instruction.
// Latency: REQ to inst_valid is at least 2 cycles; one instruction per 3 cycles at best.
// Backpressure: REQ holds until imem_gnt, WAIT until imem_rvalid, VALID until inst_ready.
// Ports: clk, rst_n (async, active-low); fif (fetch_unit_if.master) carries the
//   imem request/grant/response, the decode valid/ready hand-off and the PC loop.
// Option: FETCH_MISALIGN_TRAP_EN adds the fetch_misaligned output and a TRAP state;
//   without it the low two bits of pc_next are dropped on load.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master fif
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic         fetch_misaligned
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    VALID
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    TRAP
`endif
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic [31:0] pc_load_val;
  logic        pc_load;
  logic        inst_load;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        trap_set;
  logic        misaligned_q;
`endif

`ifdef FETCH_MISALIGN_TRAP_EN
  // keep the faulting PC intact so the trap handler sees the real target
  assign pc_load_val = fif.pc_next;
`else
  assign pc_load_val = {fif.pc_next[31:2], 2'b00};
`endif

  always_comb begin
    state_d   = state_q;
    pc_load   = 1'b0;
    inst_load = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    trap_set  = 1'b0;
`endif
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (fif.imem_gnt) state_d = WAIT;
      end
      WAIT: begin
        // rvalid is only honoured here, so a response coincident with
        // the grant (protocol violation) is never captured
        if (fif.imem_rvalid) begin
          inst_load = 1'b1;
          state_d   = VALID;
        end
      end
      VALID: begin
        if (fif.inst_ready) begin
          pc_load = 1'b1;
          state_d = REQ;
`ifdef FETCH_MISALIGN_TRAP_EN
          if (fif.pc_next[1:0] != 2'b00) begin
            trap_set = 1'b1;
            state_d  = TRAP;
          end
`endif
        end
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      TRAP: state_d = TRAP;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      if (pc_load) pc_q <= pc_load_val;
      if (inst_load) inst_q <= fif.imem_rdata;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  // sticky until reset; only the trap entry sets it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misaligned_q <= 1'b0;
    end else if (trap_set) begin
      misaligned_q <= 1'b1;
    end
  end

  assign fetch_misaligned = misaligned_q;
`endif

  // request outputs decode registered state only: no path from imem_gnt
  assign fif.imem_req   = (state_q == REQ);
  assign fif.imem_addr  = (state_q == REQ) ? {pc_q[31:2], 2'b00} : 32'h0;
  assign fif.inst_valid = (state_q == VALID);
  assign fif.inst       = inst_q;
  assign fif.pc_current = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Purpose: self-checking bench for fetch_unit against a transaction-level model.
// Latency: checks REQ->VALID spacing, stall lengths and reset recovery cycle-exactly.
// Backpressure: memory grant/response delays and inst_ready are varied directed and random.
module tb_fetch_unit;
  localparam logic [31:0] RST_PC = 32'h100;

  logic clk;
  logic rst_n;
  fetch_unit_if fif();
`ifdef FETCH_MISALIGN_TRAP_EN
  logic fetch_misaligned;
`endif

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fif   (fif)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .fetch_misaligned (fetch_misaligned)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // memory contents: a fixed function of the word address
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'hDEAD_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- memory responder ----------------
  int          gnt_delay = 0;
  int          rv_delay  = 0;
  bit          rand_mem  = 0;
  int          spur_req  = 0;
  int          spur_done = 0;
  bit          pend, l_req, l_gnt, l_rv;
  logic [31:0] paddr, l_addr;
  int          gcnt, rcnt;

  initial begin
    fif.imem_gnt    = 1'b0;
    fif.imem_rvalid = 1'b0;
    fif.imem_rdata  = 32'h0;
    pend = 0; l_req = 0; l_gnt = 0; l_rv = 0; gcnt = 0; rcnt = 0;
    paddr = 32'h0; l_addr = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        pend = 0; l_req = 0; l_gnt = 0; l_rv = 0; gcnt = 0; rcnt = 0;
        fif.imem_gnt    = 1'b0;
        fif.imem_rvalid = 1'b0;
      end else begin
        if (l_req && l_gnt) begin
          pend = 1; paddr = l_addr; rcnt = 0;
        end else if (pend && l_rv) begin
          pend = 0;
        end
        fif.imem_gnt    = 1'b0;
        fif.imem_rvalid = 1'b0;
        fif.imem_rdata  = $urandom;
        if (fif.imem_req && !pend) begin
          if (rand_mem) fif.imem_gnt = (($urandom % 3) == 0);
          else if (gcnt >= gnt_delay) fif.imem_gnt = 1'b1;
          else gcnt++;
          if (fif.imem_gnt) gcnt = 0;
        end else if (rand_mem && (($urandom % 8) == 0)) begin
          fif.imem_gnt = 1'b1;   // stray grant with no request
        end
        if (pend) begin
          if (rand_mem) fif.imem_rvalid = (($urandom % 3) == 0);
          else if (rcnt >= rv_delay) fif.imem_rvalid = 1'b1;
          else rcnt++;
          if (fif.imem_rvalid) fif.imem_rdata = word_of(paddr);
        end else if ((rand_mem && (($urandom % 8) == 0)) || (spur_done < spur_req)) begin
          fif.imem_rvalid = 1'b1;  // stray response, must be ignored
          fif.imem_rdata  = 32'hBAD0_BAD0;
          if (spur_done < spur_req) spur_done++;
        end
        l_req  = fif.imem_req;
        l_addr = fif.imem_addr;
        l_gnt  = fif.imem_gnt;
        l_rv   = fif.imem_rvalid;
      end
    end
  end

  // ---------------- reference model + compare ----------------
  logic [31:0] m_pc, m_inst, m_addr;
  bit          m_idle, m_out, m_have, m_trap, m_mis;
  bit          exp_req, prev_req, prev_val;
  int          rlen;
  int          req_cyc_q[$];
  logic [31:0] req_addr_q[$];
  int          req_len_q[$];
  int          val_cyc_q[$];
  logic [31:0] val_inst_q[$];

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      chk("rst_req",   32'(fif.imem_req), 32'h0);
      chk("rst_addr",  fif.imem_addr, 32'h0);
      chk("rst_valid", 32'(fif.inst_valid), 32'h0);
      chk("rst_inst",  fif.inst, 32'h0);
      chk("rst_pc",    fif.pc_current, RST_PC);
`ifdef FETCH_MISALIGN_TRAP_EN
      chk("rst_mis",   32'(fetch_misaligned), 32'h0);
`endif
      m_pc = RST_PC; m_inst = 32'h0; m_addr = 32'h0;
      m_idle = 1; m_out = 0; m_have = 0; m_trap = 0; m_mis = 0;
      prev_req = 0; prev_val = 0; rlen = 0;
    end else begin
      exp_req = !m_idle && !m_out && !m_have && !m_trap;
      chk("req", 32'(fif.imem_req), 32'(exp_req));
      if (exp_req) chk("addr", fif.imem_addr, {m_pc[31:2], 2'b00});
      chk("valid", 32'(fif.inst_valid), 32'(m_have));
      if (m_have) chk("inst", fif.inst, m_inst);
      chk("pc", fif.pc_current, m_pc);
`ifdef FETCH_MISALIGN_TRAP_EN
      chk("mis", 32'(fetch_misaligned), 32'(m_mis));
`endif
      // event log for the directed timing checks
      if (fif.imem_req && !prev_req) begin
        req_cyc_q.push_back(cyc);
        req_addr_q.push_back(fif.imem_addr);
        rlen = 0;
      end
      if (fif.imem_req) rlen++;
      if (!fif.imem_req && prev_req) req_len_q.push_back(rlen);
      if (fif.inst_valid && !prev_val) begin
        val_cyc_q.push_back(cyc);
        val_inst_q.push_back(fif.inst);
      end
      prev_req = fif.imem_req;
      prev_val = fif.inst_valid;
      // advance the model across the coming edge
      if (m_idle) begin
        m_idle = 0;
      end else if (exp_req && fif.imem_gnt) begin
        m_out = 1; m_addr = m_pc;
      end else if (m_out && fif.imem_rvalid) begin
        m_out = 0; m_have = 1; m_inst = word_of(m_addr);
      end else if (m_have && fif.inst_ready) begin
        m_have = 0;
`ifdef FETCH_MISALIGN_TRAP_EN
        m_pc = fif.pc_next;
        if (fif.pc_next[1:0] != 2'b00) begin
          m_trap = 1; m_mis = 1;
        end
`else
        m_pc = {fif.pc_next[31:2], 2'b00};
`endif
      end
    end
  end

  // ---------------- stimulus ----------------
  int mode = 0;   // 0 stream pc+4, 1 stall with toggling pc_next, 2 random, 3 manual
  int rel;

  task automatic drive();
    case (mode)
      0: begin
        fif.inst_ready = 1'b1;
        fif.pc_next    = fif.pc_current + 32'd4;
      end
      1: begin
        fif.inst_ready = 1'b0;
        fif.pc_next    = (fif.pc_next == 32'h200) ? 32'h300 : 32'h200;
      end
      2: begin
        fif.inst_ready = (($urandom % 4) != 0);
        if (($urandom % 10) < 7) fif.pc_next = fif.pc_current + 32'd4;
        else fif.pc_next = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
        fif.pc_next[1:0] = 2'b00;
`endif
      end
      default: ;
    endcase
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      drive();
    end
  endtask

  task automatic clear_logs();
    req_cyc_q.delete(); req_addr_q.delete(); req_len_q.delete();
    val_cyc_q.delete(); val_inst_q.delete();
  endtask

  initial begin
    fif.inst_ready = 1'b0;
    fif.pc_next    = 32'h0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rel = cyc;

    // first fetch after reset, then a sequential stream
    mode = 0;
    run(12);
    if (req_cyc_q.size() < 3 || val_cyc_q.size() < 1) begin
      chk("seq_count", 32'(req_cyc_q.size()), 32'd3);
    end else begin
      chk("first_req_cyc", 32'(req_cyc_q[0]), 32'(rel + 2));
      chk("first_addr",    req_addr_q[0], 32'h100);
      chk("first_valid",   32'(val_cyc_q[0] - req_cyc_q[0]), 32'd2);
      chk("first_inst",    val_inst_q[0], 32'hDEAD_0100);
      chk("seq_addr1",     req_addr_q[1], 32'h104);
      chk("seq_addr2",     req_addr_q[2], 32'h108);
      chk("seq_gap1",      32'(req_cyc_q[1] - req_cyc_q[0]), 32'd3);
      chk("seq_gap2",      32'(req_cyc_q[2] - req_cyc_q[1]), 32'd3);
    end

    // grant withheld 5 cycles, response withheld 4 cycles
    mode = 1;
    run(5);
    gnt_delay = 5;
    rv_delay  = 4;
    clear_logs();
    mode = 0;
    run(40);
    if (req_cyc_q.size() < 2 || req_len_q.size() < 1 || val_cyc_q.size() < 1) begin
      chk("stall_count", 32'(req_cyc_q.size()), 32'd2);
    end else begin
      chk("stall_req_len", 32'(req_len_q[0]), 32'd6);
      chk("stall_valid",   32'(val_cyc_q[0] - req_cyc_q[0]), 32'd11);
      chk("stall_period",  32'(req_cyc_q[1] - req_cyc_q[0]), 32'd12);
    end

    // decode stalls while pc_next toggles; only the accept-cycle value loads
    gnt_delay = 0;
    rv_delay  = 0;
    mode = 1;
    run(15);
    chk("hold_valid", 32'(fif.inst_valid), 32'h1);
    clear_logs();
    run(10);
    chk("hold_no_new", 32'(val_cyc_q.size() + req_cyc_q.size()), 32'd0);
    fif.inst_ready = 1'b1;
    fif.pc_next    = 32'h400;
    clear_logs();
    run(5);
    chk("accept_pc", fif.pc_current, 32'h400);
    if (req_addr_q.size() < 1) chk("accept_req", 32'd0, 32'd1);
    else chk("accept_addr", req_addr_q[0], 32'h400);

    // reset asserted while waiting for a response, then a stray rvalid
    rv_delay = 20;
    mode = 0;
    run(6);
    @(posedge clk);
    #1 rst_n = 1'b0;
    run(2);
    rst_n = 1'b1;
    spur_req++;
    rv_delay = 0;
    rel = cyc;
    clear_logs();
    run(8);
    if (req_cyc_q.size() < 1 || val_inst_q.size() < 1) begin
      chk("rst_refetch", 32'(req_cyc_q.size()), 32'd1);
    end else begin
      chk("rst_req_cyc", 32'(req_cyc_q[0]), 32'(rel + 2));
      chk("rst_addr0",   req_addr_q[0], RST_PC);
      chk("rst_inst0",   val_inst_q[0], 32'hDEAD_0100);
    end

    // randomized traffic with stray grants/responses
    rand_mem = 1;
    mode = 2;
    run(3000);
    rand_mem = 0;

    // misaligned next-PC on accept
    mode = 1;
    run(10);
    chk("mis_pre_valid", 32'(fif.inst_valid), 32'h1);
    fif.inst_ready = 1'b1;
    fif.pc_next    = 32'h102;
    clear_logs();
    run(8);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("mis_flag",  32'(fetch_misaligned), 32'h1);
    chk("mis_pc",    fif.pc_current, 32'h102);
    chk("mis_noreq", 32'(req_cyc_q.size()), 32'd0);
`else
    chk("mis_pc",    fif.pc_current, 32'h100);
    if (req_addr_q.size() < 1) chk("mis_req", 32'd0, 32'd1);
    else chk("mis_addr", req_addr_q[0], 32'h100);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
